// File: rtl/decode_hazard_stage.sv
// Fetch/decode pipeline register with load-use bubble insertion and flush squash.
// A load in EX whose destination is read by the held instruction costs one nop bubble.
//
// state | meaning
// RUN   | normal flow; a load-use match on the held instruction inserts a bubble
// HOLD  | bubble already issued for this load; the held instruction advances next edge
module decode_hazard_stage #(
  parameter logic [31:0] NOP_INSTR  = 32'h34000000,
  parameter logic [23:0] NOP_BUNDLE = 24'h0E2531,
  parameter logic [31:0] RESET_PC   = 32'h00400000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction_in,
  input  logic [23:0]      bundle_in,
  input  logic [31:0]      pc_seq_in,
  input  logic             flush_in,
  input  logic             ex_mem_read_in,
  input  logic [4:0]       ex_rt_in,
  output logic [31:0]      instruction_out,
  output logic [23:0]      bundle_out,
  output logic [31:0]      pc_seq_out,
  output logic [4:0]       rs_out,
  output logic [4:0]       rt_out,
  output logic             valid_out,
  output logic             stall_out,
  output logic [CNT_W-1:0] bubble_count_out
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [31:0]      h_instr;
  logic [23:0]      h_bundle;
  logic [31:0]      h_pc;
  logic             h_valid;
  logic [CNT_W-1:0] bubble_count;

  logic [5:0] h_opcode;
  logic       uses_rt;
  logic       rs_match;
  logic       rt_match;
  logic       hazard;

  // R-type, beq, bne and sw read rt as a source; other opcodes write it.
  always_comb begin
    h_opcode = h_instr[31:26];
    uses_rt  = (h_opcode == 6'h00) || (h_opcode == 6'h04) ||
               (h_opcode == 6'h05) || (h_opcode == 6'h2B);
    rs_match = (ex_rt_in == h_instr[25:21]);
    rt_match = uses_rt && (ex_rt_in == h_instr[20:16]);
    hazard   = (state == RUN) && h_valid && ex_mem_read_in &&
               (ex_rt_in != 5'd0) && (rs_match || rt_match);
  end

  assign stall_out = hazard && !flush_in;

  always_comb begin
    if (stall_out) begin
      instruction_out = NOP_INSTR;
      bundle_out      = NOP_BUNDLE;
      valid_out       = 1'b0;
    end else begin
      instruction_out = h_instr;
      bundle_out      = h_bundle;
      valid_out       = h_valid;
    end
    pc_seq_out = h_pc;
    rs_out     = instruction_out[25:21];
    rt_out     = instruction_out[20:16];
  end

  assign bubble_count_out = bubble_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      h_instr      <= NOP_INSTR;
      h_bundle     <= NOP_BUNDLE;
      h_pc         <= RESET_PC;
      h_valid      <= 1'b0;
      bubble_count <= '0;
    end else if (flush_in) begin
      state    <= RUN;
      h_instr  <= NOP_INSTR;
      h_bundle <= NOP_BUNDLE;
      h_pc     <= pc_seq_in;
      h_valid  <= 1'b0;
    end else if (hazard) begin
      state <= HOLD;
      if (bubble_count != {CNT_W{1'b1}})
        bubble_count <= bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      state    <= RUN;
      h_instr  <= instruction_in;
      h_bundle <= bundle_in;
      h_pc     <= pc_seq_in;
      h_valid  <= 1'b1;
    end
  end

endmodule
